// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU. Owns a word-organised
// data RAM, accepts one byte/half/word load or store per valid/ready
// handshake, and answers each request with a single-cycle resp_valid pulse.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        error
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam int         AB        = ADDR_WIDTH + 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AB-1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              uns_q, uns_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;
  logic              resp_q, ready_q;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [31:0]           rword_s;
  logic                  unused_addr_s;

  // Upper address bits wrap away; they are intentionally not decoded.
  assign unused_addr_s = ^addr[31:AB];
  assign word_idx_s    = addr_q[AB-1:2];
  assign rword_s       = mem_q[word_idx_s];

  // Rejects read/write ambiguity, the reserved size code and misalignment.
  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic [1:0] sz, input logic [1:0] lane);
    logic misal;
    case (sz)
      2'b00:   misal = 1'b0;
      2'b01:   misal = lane[0];
      2'b10:   misal = (lane != 2'b00);
      default: misal = 1'b1;
    endcase
    return (rd == wr) | misal;
  endfunction

  // Right-aligns the addressed byte/half and applies sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Merges store data into the old word; unselected byte lanes are kept.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] mask;
    case (sz)
      2'b00: begin
        be   = 4'b0001 << lane;
        data = {4{wd[7:0]}};
      end
      2'b01: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        data = {2{wd[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        data = wd;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return (old & ~mask) | (data & mask);
  endfunction

  // Next-state logic: request capture, wait countdown, load result and error.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        rdata_d = 32'h0000_0000;
        error_d = 1'b0;
        if (req_valid) begin
          addr_d  = addr[AB-1:0];
          wdata_d = wdata;
          size_d  = size;
          rd_d    = mem_read;
          wr_d    = mem_write;
          uns_d   = load_unsigned;
          if (is_illegal(mem_read, mem_write, size, addr[1:0])) begin
            state_d = S_RESP;
            error_d = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        rdata_d = rd_q ? load_extract(rword_s, size_q, addr_q[1:0], uns_q) : 32'h0000_0000;
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = 32'h0000_0000;
        error_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, request and response registers; rst returns the unit to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      size_q  <= 2'b00;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      error_q <= 1'b0;
      resp_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      resp_q  <= (state_d == S_RESP);
      ready_q <= (state_d == S_IDLE);
    end
  end

  // RAM write port: commits at the ACCESS edge unless rst wins that edge.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_ACCESS) && wr_q) begin
      mem_q[word_idx_s] <= store_merge(rword_s, wdata_q, size_q, addr_q[1:0]);
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_q;
  assign rdata      = rdata_q;
  assign error      = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array memory model predicts
// each response, a negedge monitor pops and compares data, error and timing.
module tb_load_store_unit;
  localparam int WS = 1;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, mem_read, mem_write, load_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, error;

  load_store_unit #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .error(error));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  logic [7:0] mdl [4096];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid required=no_response (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("rdata", rdata, e.rdata);
        check("error", {31'b0, error}, {31'b0, e.err});
        check("latency", cyc, e.due);
      end
    end
  end

  function automatic logic legal_f(input logic rd, input logic wr, input logic [1:0] sz,
                                   input logic [31:0] a);
    return (rd != wr) && ((sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) ||
                          (sz == 2'd2 && a[1:0] == 2'd0));
  endfunction

  // Reference: a legal load reads model bytes, a legal store writes them.
  function automatic logic [31:0] model_op(input logic rd, input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] wd);
    int b;
    int n;
    logic [31:0] v;
    b = int'(a[11:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'h0;
    if (rd) begin
      for (int i = 0; i < n; i++) v = v | (32'(mdl[b + i]) << (8 * i));
      if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
      if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
      return v;
    end
    for (int i = 0; i < n; i++) mdl[b + i] = wd[8*i +: 8];
    return 32'h0;
  endfunction

  task automatic start_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int acc, output int waited);
    @(negedge clk);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; size = sz;
    load_unsigned = uns; addr = a; wdata = wd;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready (cycle %0d)", cyc);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit keep,
                       output int acc, output int waited);
    exp_t e;
    logic ok;
    start_req(rd, wr, sz, uns, a, wd, acc, waited);
    if (acc >= 0) begin
      ok      = legal_f(rd, wr, sz, a);
      e.err   = !ok;
      e.rdata = ok ? model_op(rd, sz, uns, a, wd) : 32'h0;
      e.due   = ok ? acc + WS + 2 : acc;
      sbq.push_back(e);
    end
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd);
    int acc;
    int w;
    issue(rd, wr, sz, uns, a, wd, 1'b0, acc, w);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_prev, w;
    rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'd0;
    load_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_resp", {31'b0, resp_valid}, 32'd0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_error", {31'b0, error}, 32'd0);

    // Word round trip
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    drain();
    @(negedge clk);
    check("idle_rdata", rdata, 32'h0);
    check("rt_value", model_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h0), 32'hDEADBEEF);

    // Byte store, lane extension
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h0);
    op(1'b0, 1'b1, 2'd0, 1'b0, 32'h202, 32'h000000F0);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    op(1'b1, 1'b0, 2'd0, 1'b0, 32'h202, 32'h0);
    op(1'b1, 1'b0, 2'd0, 1'b1, 32'h202, 32'h0);

    // Halfword extension
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h0);
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'h300, 32'h00008001);
    op(1'b1, 1'b0, 2'd1, 1'b0, 32'h300, 32'h0);
    op(1'b1, 1'b0, 2'd1, 1'b1, 32'h300, 32'h0);
    op(1'b1, 1'b0, 2'd1, 1'b0, 32'h302, 32'h0);

    // Illegal requests
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'h105, 32'h00001234);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
    op(1'b1, 1'b1, 2'd2, 1'b0, 32'h108, 32'h0);
    op(1'b0, 1'b0, 2'd0, 1'b0, 32'h108, 32'h0);
    op(1'b1, 1'b0, 2'd3, 1'b0, 32'h108, 32'h0);

    // Address wrap
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    drain();

    // Busy handling: req_valid held high, fresh operands driven while busy
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, acc_prev, w);
    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 1'b0, 2'd0, k[0], 32'h202, 32'h0, 1'b1, acc, w);
      check("busy_cycles", w, WS + 3);
      check("accept_spacing", acc - acc_prev, WS + 4);
      acc_prev = acc;
    end
    req_valid = 1'b0;
    drain();

    // Reset during WAIT discards the store
    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11111111);
    drain();
    start_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hAAAAAAAA, acc, w);
    req_valid = 1'b0;
    pulse_rst();
    check("rst_wait_ready", {31'b0, req_ready}, 32'd1);
    check("rst_wait_resp", {31'b0, resp_valid}, 32'd0);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    drain();

    // Reset at the ACCESS edge also discards the store
    start_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hBBBBBBBB, acc, w);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    pulse_rst();
    check("rst_access_resp", {31'b0, resp_valid}, 32'd0);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    drain();

    // Reset in RESP: the store has committed, the pulse ends
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h5A5A5A5A, 1'b0, acc, w);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    pulse_rst();
    check("rst_resp_drop", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_pending", sbq.size(), 32'd0);
    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    drain();

    // Random traffic in words 0..63 with random upper address bits
    for (int i = 0; i < 64; i++)
      op(1'b0, 1'b1, 2'd2, 1'b0, ($urandom & 32'hFFFF_F000) | 32'(i << 2), $urandom);
    for (int i = 0; i < 150; i++) begin
      logic rd, wr;
      int   sel;
      sel = $urandom_range(0, 9);
      rd  = (sel == 0) ? 1'($urandom) : (sel < 6);
      wr  = (sel == 0) ? rd : !rd;
      op(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom),
         ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(0, 3)),
         $urandom);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
